// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between NREQ writeback
//   sources (ALU, load unit, CSR unit, ...). A round-robin arbiter grants
//   one valid requester per cycle. The winning write is captured in a
//   one-entry output stage that drives the register-file write port. The
//   write held in that stage is compared against two read addresses, so
//   the decode stage can forward its data.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   flush                squash: no grant this cycle, output stage cleared
//   req_valid[NREQ]      per-requester write pending
//   req_addr[NREQ*AW]    requester i address at [i*AW +: AW]
//   req_data[NREQ*DW]    requester i data at [i*DW +: DW]
//   req_ready[NREQ]      one-hot grant (a transfer happens when valid & ready)
//   rf_we/rf_waddr/rf_wdata  register-file write port (one cycle after transfer)
//   grant_id             requester that produced the write currently in the stage
//   chk_addr1/2          read addresses checked against the in-flight write
//   hit1/hit2            in-flight write matches the read address (never for x0)
//   fwd_data             forwarding data (same as rf_wdata)
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic [2:0]        grant_id,
  input  logic [AW-1:0]     chk_addr1,
  input  logic [AW-1:0]     chk_addr2,
  output logic              hit1,
  output logic              hit2,
  output logic [DW-1:0]     fwd_data
);

  logic [2:0]    r_rrPtr;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_grantId;

  logic          w_found;
  logic [2:0]    w_winner;
  logic          w_xfer;
  logic [2:0]    w_nextPtr;
  logic [AW-1:0] w_winAddr;
  logic [DW-1:0] w_winData;

  // Round-robin scan: walk the valid vector starting at the pointer and
  // wrapping modulo NREQ; the first set bit wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rrPtr) + k) % NREQ]) begin
        w_found  = 1'b1;
        w_winner = 3'((int'(r_rrPtr) + k) % NREQ);
      end
    end
  end

  // Flush and reset both suppress the grant; reset does so without waiting
  // for a clock edge so no requester sees a handshake while rst is high.
  assign w_xfer = w_found && !flush && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_xfer && (w_winner == 3'(i));
    end
  end

  assign w_nextPtr = 3'((int'(w_winner) + 1) % NREQ);
  assign w_winAddr = req_addr[int'(w_winner)*AW +: AW];
  assign w_winData = req_data[int'(w_winner)*DW +: DW];

  // Pointer and output stage. A transfer to x0 still completes the handshake
  // and rotates the pointer, but nothing is written. When no write is issued
  // the address, data and id hold their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrPtr   <= 3'd0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_grantId <= 3'd0;
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        r_rrPtr <= w_nextPtr;
        if (w_winAddr != '0) begin
          r_we      <= 1'b1;
          r_waddr   <= w_winAddr;
          r_wdata   <= w_winData;
          r_grantId <= w_winner;
        end
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign grant_id = r_grantId;

  // Hazard detection against the write sitting in the output stage; x0 is
  // hardwired to zero so it never forwards.
  assign hit1     = r_we && (chk_addr1 == r_waddr) && (chk_addr1 != '0);
  assign hit2     = r_we && (chk_addr2 == r_waddr) && (chk_addr2 != '0);
  assign fwd_data = r_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [DW-1:0] D0 = 32'hDEADBEEF;
  localparam logic [DW-1:0] D1 = 32'h00001234;
  localparam logic [DW-1:0] D2 = 32'hCAFEF00D;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [2:0]        grant_id;
  logic [AW-1:0]     chk_addr1 = '0;
  logic [AW-1:0]     chk_addr2 = '0;
  logic              hit1;
  logic              hit2;
  logic [DW-1:0]     fwd_data;

  assign req_data = {D2, D1, D0};

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .grant_id(grant_id),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hit1(hit1), .hit2(hit2), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    valid;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          fl;
    logic [2:0]    expReady;
    logic          expWe;
    logic [AW-1:0] expWaddr;
    logic [DW-1:0] expWdata;
    logic [2:0]    expGid;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [2:0]    gid;
  } stage_t;

  vec_t   tbl[17];
  stage_t expQ[$];
  int     nVec  = 0;
  int     nMiss = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic fl);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    flush     = fl;
  endtask

  // Drive one vector, check the combinational grant, and queue the output
  // stage contents expected after the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    stage_t s;
    drive(v.valid, v.a0, v.a1, v.a2, v.fl);
    #1;
    compare($sformatf("req_ready[v%0d]", idx), 32'(req_ready), 32'(v.expReady));
    s.we    = v.expWe;
    s.waddr = v.expWaddr;
    s.wdata = v.expWdata;
    s.gid   = v.expGid;
    expQ.push_back(s);
  endtask

  task automatic checkOutput(input int idx);
    stage_t s;
    if (expQ.size() == 0) begin
      compare($sformatf("scoreboard_empty[v%0d]", idx), 32'd0, 32'd1);
    end else begin
      s = expQ.pop_front();
      compare($sformatf("rf_we[v%0d]", idx),    32'(rf_we),    32'(s.we));
      compare($sformatf("rf_waddr[v%0d]", idx), 32'(rf_waddr), 32'(s.waddr));
      compare($sformatf("rf_wdata[v%0d]", idx), rf_wdata,      s.wdata);
      compare($sformatf("grant_id[v%0d]", idx), 32'(grant_id), 32'(s.gid));
    end
  endtask

  initial begin
    // valid, a0, a1, a2, flush | ready, we, waddr, wdata, gid (after the edge)
    tbl[0]  = '{3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 3'b001, 1'b1, 5'd5, D0, 3'd0};
    tbl[1]  = '{3'b010, 5'd0, 5'd2, 5'd0, 1'b0, 3'b010, 1'b1, 5'd2, D1, 3'd1};
    tbl[2]  = '{3'b100, 5'd0, 5'd0, 5'd3, 1'b0, 3'b100, 1'b1, 5'd3, D2, 3'd2};
    tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 3'b001, 1'b1, 5'd1, D0, 3'd0};
    tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 3'b010, 1'b1, 5'd2, D1, 3'd1};
    tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 3'b100, 1'b1, 5'd3, D2, 3'd2};
    tbl[6]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 3'b001, 1'b1, 5'd1, D0, 3'd0};
    tbl[7]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 3'b010, 1'b1, 5'd2, D1, 3'd1};
    tbl[8]  = '{3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 3'b100, 1'b1, 5'd3, D2, 3'd2};
    tbl[9]  = '{3'b011, 5'd1, 5'd0, 5'd0, 1'b0, 3'b001, 1'b1, 5'd1, D0, 3'd0};
    tbl[10] = '{3'b010, 5'd0, 5'd0, 5'd0, 1'b0, 3'b010, 1'b0, 5'd1, D0, 3'd0};
    tbl[11] = '{3'b011, 5'd4, 5'd6, 5'd0, 1'b0, 3'b001, 1'b1, 5'd4, D0, 3'd0};
    tbl[12] = '{3'b010, 5'd0, 5'd6, 5'd0, 1'b0, 3'b010, 1'b1, 5'd6, D1, 3'd1};
    tbl[13] = '{3'b011, 5'd4, 5'd6, 5'd0, 1'b1, 3'b000, 1'b0, 5'd6, D1, 3'd1};
    tbl[14] = '{3'b011, 5'd4, 5'd6, 5'd0, 1'b0, 3'b001, 1'b1, 5'd4, D0, 3'd0};
    tbl[15] = '{3'b010, 5'd0, 5'd6, 5'd0, 1'b0, 3'b010, 1'b1, 5'd6, D1, 3'd1};
    tbl[16] = '{3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 5'd6, D1, 3'd1};

    // Reset: outputs cleared and no grant even with every requester valid.
    #1 rst = 1'b1;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 1'b0);
    #2;
    compare("reset_rf_we",     32'(rf_we),     32'd0);
    compare("reset_rf_waddr",  32'(rf_waddr),  32'd0);
    compare("reset_rf_wdata",  rf_wdata,       32'd0);
    compare("reset_grant_id",  32'(grant_id),  32'd0);
    compare("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i], i);
      @(posedge clk);
      #1;
      checkOutput(i);
      @(negedge clk);
    end

    // Hazard check: write to x7 in flight (pointer is 2, so requester 0 wins).
    drive(3'b001, 5'd7, 5'd0, 5'd0, 1'b0);
    #1 compare("hz_ready0", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    chk_addr1 = 5'd7;
    chk_addr2 = 5'd0;
    #1;
    compare("hz_rf_we",   32'(rf_we), 32'd1);
    compare("hz_hit1",    32'(hit1),  32'd1);
    compare("hz_hit2_x0", 32'(hit2),  32'd0);
    compare("hz_fwd",     fwd_data,   D0);
    chk_addr2 = 5'd7;
    chk_addr1 = 5'd3;
    #1;
    compare("hz_hit2", 32'(hit2), 32'd1);
    compare("hz_hit1_miss", 32'(hit1), 32'd0);

    // Dropped x0 write from requester 1: rf_we low, so no hit on stale x7.
    @(negedge clk);
    drive(3'b010, 5'd0, 5'd0, 5'd0, 1'b0);
    #1 compare("x0_ready1", 32'(req_ready), 32'b010);
    @(posedge clk);
    #1;
    chk_addr1 = 5'd7;
    chk_addr2 = 5'd0;
    #1;
    compare("x0_rf_we",  32'(rf_we),    32'd0);
    compare("x0_waddr",  32'(rf_waddr), 32'd7);
    compare("x0_hit1",   32'(hit1),     32'd0);
    compare("x0_hit2",   32'(hit2),     32'd0);

    // Pointer is now 2: requester 0 wins and moves the pointer to 1.
    @(negedge clk);
    drive(3'b001, 5'd9, 5'd0, 5'd0, 1'b0);
    #1 compare("pre_rst_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1 compare("pre_rst_we", 32'(rf_we), 32'd1);
    drive(3'b101, 5'd9, 5'd0, 5'd12, 1'b0);

    // Mid-cycle reset: stage clears with no clock edge; the write is lost.
    #2 rst = 1'b1;
    #1;
    compare("midrst_rf_we",    32'(rf_we),     32'd0);
    compare("midrst_waddr",    32'(rf_waddr),  32'd0);
    compare("midrst_wdata",    rf_wdata,       32'd0);
    compare("midrst_gid",      32'(grant_id),  32'd0);
    compare("midrst_ready",    32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b101, 5'd11, 5'd0, 5'd12, 1'b0);
    #1;
    // Pointer back to 0, so requester 0 beats requester 2.
    compare("postrst_ready", 32'(req_ready), 32'b001);
    compare("postrst_we",    32'(rf_we),     32'd0);
    @(posedge clk);
    #1;
    compare("postrst_rf_we", 32'(rf_we),    32'd1);
    compare("postrst_waddr", 32'(rf_waddr), 32'd11);
    compare("postrst_wdata", rf_wdata,      D0);
    compare("postrst_gid",   32'(grant_id), 32'd0);
    @(negedge clk);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
